// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
// Holds the sequencer state encoding and the bundle of stall/flush control bits.
package pipeline_pkg;

    localparam int          REG_ADDR_W      = 5;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic flush_if_id;
        logic stall_id_ex;
        logic flush_id_ex;
        logic flush_ex_mem;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_NONE = '{default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_lu_cmp.sv
// Load-use hazard comparator: flags an ID-stage source that matches a load's
// destination in EX. Purely combinational so the forwarding unit can share it.
module hazard_lu_cmp
    import pipeline_pkg::*;
(
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    output logic                  o_lu_hit
);

    logic w_rd_nonzero;
    logic w_rs1_match;
    logic w_rs2_match;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_rd_nonzero = |i_ex_rd;
    assign w_rs1_match  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_match  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_lu_hit     = i_ex_mem_read && w_rd_nonzero && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// redirects, MUL/DIV waits with timeout, fetch wait states and saturating perf counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MD_TIMEOUT      = 64,
    parameter int PERF_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_use_rs1,
    input  logic                  i_id_use_rs2,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_branch_taken,
    input  logic                  i_ex_muldiv_start,
    input  logic                  i_muldiv_done,
    input  logic                  i_imem_ready,
    output logic                  o_stall_pc,
    output logic                  o_stall_if_id,
    output logic                  o_flush_if_id,
    output logic                  o_stall_id_ex,
    output logic                  o_flush_id_ex,
    output logic                  o_flush_ex_mem,
    output logic                  o_muldiv_timeout,
    output logic [PERF_W-1:0]     o_perf_stall_cyc,
    output logic [PERF_W-1:0]     o_perf_flush_cnt
);

    localparam int LU_CNT_W = $clog2(LU_STALL_CYCLES + 1);
    localparam int MD_CNT_W = $clog2(MD_TIMEOUT);

    localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LU_STALL_CYCLES - 1);
    localparam logic [LU_CNT_W-1:0] LU_ONE  = LU_CNT_W'(1);
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

    localparam ctrl_out_t CTRL_MD = '{stall_pc: 1'b1, stall_if_id: 1'b1, stall_id_ex: 1'b1,
                                      flush_ex_mem: 1'b1, default: 1'b0};
    localparam ctrl_out_t CTRL_BR = '{flush_if_id: 1'b1, flush_id_ex: 1'b1, default: 1'b0};
    localparam ctrl_out_t CTRL_LU = '{stall_pc: 1'b1, stall_if_id: 1'b1, flush_id_ex: 1'b1,
                                      default: 1'b0};
    localparam ctrl_out_t CTRL_IM = '{stall_pc: 1'b1, flush_if_id: 1'b1, default: 1'b0};

    ctrl_state_t         r_state;
    ctrl_state_t         w_state_nxt;
    logic [LU_CNT_W-1:0] r_lu_cnt;
    logic [LU_CNT_W-1:0] w_lu_cnt_nxt;
    logic [MD_CNT_W-1:0] r_md_cnt;
    logic [MD_CNT_W-1:0] w_md_cnt_nxt;
    logic                r_md_timeout;
    logic [PERF_W-1:0]   r_perf_stall_cyc;
    logic [PERF_W-1:0]   r_perf_flush_cnt;

    ctrl_out_t           w_ctrl;
    logic                w_lu_hit;
    logic                w_md_pending;
    logic                w_md_expire;
    logic                w_md_busy;
    logic                w_timeout_set;
    logic                w_flush_evt;

    hazard_lu_cmp u_lu_cmp (
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .o_lu_hit      (w_lu_hit)
    );

    assign w_md_pending = ((r_state == MD_WAIT) || ((r_state == RUN) && i_ex_muldiv_start))
                          && !i_muldiv_done;
    assign w_md_expire  = (r_state == MD_WAIT) && !i_muldiv_done && (r_md_cnt == MD_LAST);
    assign w_md_busy    = w_md_pending && !w_md_expire;

    // NOTE: every variable gets a default before the decision tree, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_ctrl        = CTRL_NONE;
        w_state_nxt   = r_state;
        w_lu_cnt_nxt  = r_lu_cnt;
        w_md_cnt_nxt  = r_md_cnt;
        w_timeout_set = 1'b0;
        w_flush_evt   = 1'b0;

        if (w_md_busy) begin
            w_ctrl = CTRL_MD;
            if (r_state == RUN) begin
                w_state_nxt  = MD_WAIT;
                w_md_cnt_nxt = '0;
            end else begin
                w_md_cnt_nxt = r_md_cnt + MD_CNT_W'(1);
            end
        end else begin
            // Leaving MD_WAIT on done or on timeout; the same cycle may still redirect.
            if (r_state == MD_WAIT) begin
                w_state_nxt = RUN;
            end
            w_timeout_set = w_md_expire;

            if (i_ex_branch_taken) begin
                w_ctrl      = CTRL_BR;
                w_state_nxt = RUN;
                w_flush_evt = 1'b1;
            end else if (r_state == LU_STALL) begin
                w_ctrl       = CTRL_LU;
                w_lu_cnt_nxt = r_lu_cnt - LU_ONE;
                if (r_lu_cnt == LU_ONE) begin
                    w_state_nxt = RUN;
                end
            end else if ((r_state == RUN) && w_lu_hit) begin
                w_ctrl = CTRL_LU;
                if (LU_STALL_CYCLES > 1) begin
                    w_state_nxt  = LU_STALL;
                    w_lu_cnt_nxt = LU_INIT;
                end
            end else if ((r_state == RUN) && !i_imem_ready) begin
                w_ctrl = CTRL_IM;
            end
        end
    end

    // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= RUN;
            r_lu_cnt         <= '0;
            r_md_cnt         <= '0;
            r_md_timeout     <= 1'b0;
            r_perf_stall_cyc <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (w_timeout_set) begin
                r_md_timeout <= 1'b1;
            end
            if (w_ctrl.stall_pc && (r_perf_stall_cyc != '1)) begin
                r_perf_stall_cyc <= r_perf_stall_cyc + PERF_W'(1);
            end
            if (w_flush_evt && (r_perf_flush_cnt != '1)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + PERF_W'(1);
            end
        end
    end

    // NOTE: control outputs are masked by rst so they read 0 for the whole reset pulse, not only after the edge.
    assign o_stall_pc       = w_ctrl.stall_pc     && !rst;
    assign o_stall_if_id    = w_ctrl.stall_if_id  && !rst;
    assign o_flush_if_id    = w_ctrl.flush_if_id  && !rst;
    assign o_stall_id_ex    = w_ctrl.stall_id_ex  && !rst;
    assign o_flush_id_ex    = w_ctrl.flush_id_ex  && !rst;
    assign o_flush_ex_mem   = w_ctrl.flush_ex_mem && !rst;
    assign o_muldiv_timeout = r_md_timeout;
    assign o_perf_stall_cyc = r_perf_stall_cyc;
    assign o_perf_flush_cnt = r_perf_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances share stimulus, one with default
// parameters and one with a 3-cycle load-use stall, short MUL/DIV timeout and 3-bit counters.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read;
    logic       ex_branch_taken, ex_muldiv_start, muldiv_done, imem_ready;

    logic        a_stall_pc, a_stall_if_id, a_flush_if_id, a_stall_id_ex, a_flush_id_ex, a_flush_ex_mem;
    logic        a_timeout;
    logic [31:0] a_perf_stall, a_perf_flush;
    logic        b_stall_pc, b_stall_if_id, b_flush_if_id, b_stall_id_ex, b_flush_id_ex, b_flush_ex_mem;
    logic        b_timeout;
    logic [2:0]  b_perf_stall, b_perf_flush;

    logic [5:0] ctrl_a, ctrl_b;
    assign ctrl_a = {a_stall_pc, a_stall_if_id, a_flush_if_id, a_stall_id_ex, a_flush_id_ex, a_flush_ex_mem};
    assign ctrl_b = {b_stall_pc, b_stall_if_id, b_flush_if_id, b_stall_id_ex, b_flush_id_ex, b_flush_ex_mem};

    // {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, flush_ex_mem}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_MD   = 6'b110101;
    localparam logic [5:0] C_BR   = 6'b001010;
    localparam logic [5:0] C_IM   = 6'b101000;

    int n_assert;
    int n_fail;

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .MD_TIMEOUT(64), .PERF_W(32)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd), .i_ex_branch_taken(ex_branch_taken),
        .i_ex_muldiv_start(ex_muldiv_start), .i_muldiv_done(muldiv_done), .i_imem_ready(imem_ready),
        .o_stall_pc(a_stall_pc), .o_stall_if_id(a_stall_if_id), .o_flush_if_id(a_flush_if_id),
        .o_stall_id_ex(a_stall_id_ex), .o_flush_id_ex(a_flush_id_ex), .o_flush_ex_mem(a_flush_ex_mem),
        .o_muldiv_timeout(a_timeout), .o_perf_stall_cyc(a_perf_stall), .o_perf_flush_cnt(a_perf_flush)
    );

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .MD_TIMEOUT(8), .PERF_W(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd), .i_ex_branch_taken(ex_branch_taken),
        .i_ex_muldiv_start(ex_muldiv_start), .i_muldiv_done(muldiv_done), .i_imem_ready(imem_ready),
        .o_stall_pc(b_stall_pc), .o_stall_if_id(b_stall_if_id), .o_flush_if_id(b_flush_if_id),
        .o_stall_id_ex(b_stall_id_ex), .o_flush_id_ex(b_flush_id_ex), .o_flush_ex_mem(b_flush_ex_mem),
        .o_muldiv_timeout(b_timeout), .o_perf_stall_cyc(b_perf_stall), .o_perf_flush_cnt(b_perf_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        ex_muldiv_start = 1'b0; muldiv_done = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic lu_hit_rs1();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    // Returns right after a falling edge with rst released, ready to drive the next cycle.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // Reset: hazard-looking inputs must not leak through while rst is high.
        rst = 1'b1;
        idle_inputs();
        lu_hit_rs1();
        imem_ready      = 1'b0;
        ex_muldiv_start = 1'b1;
        @(negedge clk); #1;
        chk6("reset_ctrl_a", ctrl_a, C_NONE);
        chk6("reset_ctrl_b", ctrl_b, C_NONE);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        chk6("idle_ctrl_a", ctrl_a, C_NONE);
        chk32("reset_perf_stall_a", a_perf_stall, 32'd0);
        chk32("reset_perf_flush_a", a_perf_flush, 32'd0);
        chk32("reset_timeout_a", {31'd0, a_timeout}, 32'd0);

        // Load-use via rs1: one bubble on A, three on B.
        @(negedge clk); lu_hit_rs1(); #1;
        chk6("lu_rs1_a", ctrl_a, C_LU);
        chk6("lu_rs1_b", ctrl_b, C_LU);
        @(negedge clk); idle_inputs(); #1;
        chk6("lu_release_a", ctrl_a, C_NONE);
        chk6("lu_hold1_b", ctrl_b, C_LU);
        chk32("lu_perf_stall_a", a_perf_stall, 32'd1);
        @(negedge clk); #1;
        chk6("lu_hold2_b", ctrl_b, C_LU);
        @(negedge clk); #1;
        chk6("lu_release_b", ctrl_b, C_NONE);
        chk32("lu_perf_stall_b", {29'd0, b_perf_stall}, 32'd3);

        // Load-use qualifiers.
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
        chk6("lu_rd_zero_a", ctrl_a, C_NONE);
        @(negedge clk); ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; #1;
        chk6("lu_no_use_a", ctrl_a, C_NONE);
        @(negedge clk); ex_mem_read = 1'b0; id_use_rs1 = 1'b1; #1;
        chk6("lu_not_load_a", ctrl_a, C_NONE);
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_use_rs2 = 1'b1; #1;
        chk6("lu_rs2_a", ctrl_a, C_LU);
        @(negedge clk); idle_inputs(); #1;
        chk32("lu_rs2_perf_a", a_perf_stall, 32'd1);

        // MUL/DIV: done arrives 4 cycles after start; a branch mid-wait is ignored.
        do_reset();
        ex_muldiv_start = 1'b1; #1;
        chk6("md_start_a", ctrl_a, C_MD);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            ex_muldiv_start = 1'b0;
            ex_branch_taken = (k == 2);
            #1;
            chk6("md_wait_a", ctrl_a, C_MD);
        end
        @(negedge clk); ex_branch_taken = 1'b0; muldiv_done = 1'b1; #1;
        chk6("md_done_a", ctrl_a, C_NONE);
        @(negedge clk); muldiv_done = 1'b0; #1;
        chk6("md_after_a", ctrl_a, C_NONE);
        chk32("md_perf_stall_a", a_perf_stall, 32'd4);
        chk32("md_perf_flush_a", a_perf_flush, 32'd0);

        // MUL/DIV timeout on B (MD_TIMEOUT=8): 8 stall cycles, then release and sticky flag.
        do_reset();
        ex_muldiv_start = 1'b1; #1;
        chk6("to_start_b", ctrl_b, C_MD);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); ex_muldiv_start = 1'b0; #1;
            chk6("to_wait_b", ctrl_b, C_MD);
        end
        @(negedge clk); #1;
        chk6("to_release_b", ctrl_b, C_NONE);
        chk32("to_flag_pending_b", {31'd0, b_timeout}, 32'd0);
        chk6("to_still_wait_a", ctrl_a, C_MD);
        @(negedge clk); #1;
        chk32("to_flag_b", {31'd0, b_timeout}, 32'd1);
        chk32("to_perf_sat_b", {29'd0, b_perf_stall}, 32'd7);
        chk6("to_idle_b", ctrl_b, C_NONE);
        @(negedge clk);
        @(negedge clk); #1;
        chk32("to_sticky_b", {31'd0, b_timeout}, 32'd1);
        do_reset(); #1;
        chk32("to_cleared_b", {31'd0, b_timeout}, 32'd0);

        // Branch aborts a multi-cycle load-use stall on B in its second stall cycle.
        lu_hit_rs1(); #1;
        chk6("lub_first_b", ctrl_b, C_LU);
        @(negedge clk); idle_inputs(); ex_branch_taken = 1'b1; #1;
        chk6("lub_branch_b", ctrl_b, C_BR);
        chk6("lub_branch_a", ctrl_a, C_BR);
        @(negedge clk); ex_branch_taken = 1'b0; #1;
        chk6("lub_run_b", ctrl_b, C_NONE);
        chk32("lub_perf_flush_b", {29'd0, b_perf_flush}, 32'd1);
        chk32("lub_perf_stall_b", {29'd0, b_perf_stall}, 32'd1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); ex_branch_taken = 1'b1;
        end
        @(negedge clk); ex_branch_taken = 1'b0; #1;
        chk32("flush_sat_b", {29'd0, b_perf_flush}, 32'd7);
        chk32("flush_cnt_a", a_perf_flush, 32'd8);

        // Fetch wait states and their priority against other events.
        do_reset();
        imem_ready = 1'b0; #1;
        chk6("imem_wait1_a", ctrl_a, C_IM);
        @(negedge clk); #1;
        chk6("imem_wait2_a", ctrl_a, C_IM);
        @(negedge clk); imem_ready = 1'b1; #1;
        chk6("imem_ready_a", ctrl_a, C_NONE);
        chk32("imem_perf_stall_a", a_perf_stall, 32'd2);
        @(negedge clk); imem_ready = 1'b0; lu_hit_rs1(); #1;
        chk6("lu_over_imem_a", ctrl_a, C_LU);
        @(negedge clk); idle_inputs(); imem_ready = 1'b0; ex_branch_taken = 1'b1; #1;
        chk6("branch_over_imem_a", ctrl_a, C_BR);

        // Asynchronous reset in the middle of MD_WAIT.
        @(negedge clk); idle_inputs(); ex_muldiv_start = 1'b1; #1;
        chk6("rst_md_start_a", ctrl_a, C_MD);
        @(negedge clk); ex_muldiv_start = 1'b0; #1;
        chk6("rst_md_wait_a", ctrl_a, C_MD);
        #2 rst = 1'b1;
        #1;
        chk6("rst_async_a", ctrl_a, C_NONE);
        chk6("rst_async_b", ctrl_b, C_NONE);
        chk32("rst_async_perf_a", a_perf_stall, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk6("rst_release_a", ctrl_a, C_NONE);
        @(negedge clk); lu_hit_rs1(); #1;
        chk6("rst_back_to_run_a", ctrl_a, C_LU);
        @(negedge clk); idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
